// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit strobe/handshake bundle
interface multicycle_control_unit_if;
    logic [15:0] ir_in;
    logic        mem_ready;
    logic [3:0]  reg_ld;
    logic [3:0]  reg_t;
    logic        pc_ld;
    logic        pc_t;
    logic        pc_inc;
    logic        ir_ld;
    logic        ir_t;
    logic        mar_ld;
    logic        mdr_ld;
    logic        mdr_t;
    logic        alu_t;
    logic [1:0]  alu_op;
    logic        tmp_ld;
    logic        mem_rd;
    logic        mem_wr;
    logic        halted;

    modport master (
        input  ir_in, mem_ready,
        output reg_ld, reg_t, pc_ld, pc_t, pc_inc, ir_ld, ir_t, mar_ld,
               mdr_ld, mdr_t, alu_t, alu_op, tmp_ld, mem_rd, mem_wr, halted
    );

    modport slave (
        output ir_in, mem_ready,
        input  reg_ld, reg_t, pc_ld, pc_t, pc_inc, ir_ld, ir_t, mar_ld,
               mdr_ld, mdr_t, alu_t, alu_op, tmp_ld, mem_rd, mem_wr, halted
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle fetch/decode/execute sequencer
module multicycle_control_unit (
    input  logic                          clk,
    input  logic                          rst,
    multicycle_control_unit_if.master     bus
);
    typedef enum logic [4:0] {
        ST_F0, ST_F1, ST_F2, ST_DEC, ST_MOV, ST_LDI, ST_A1, ST_A2, ST_A3,
        ST_L0, ST_L1, ST_L2, ST_S0, ST_S1, ST_S2, ST_JMP, ST_HALT
    } state_t;

    state_t state, next_state;
    logic   rst_q;
    logic   quiet;

    logic [3:0] opcode;
    logic [3:0] rd_hot, rs_hot;
    logic       unused_imm;

    assign opcode     = bus.ir_in[15:12];
    assign rd_hot     = 4'b0001 << bus.ir_in[11:10];
    assign rs_hot     = 4'b0001 << bus.ir_in[9:8];
    assign unused_imm = ^bus.ir_in[7:0];
    // Outputs stay dark during reset and the cycle after it; F0 is held through that cycle.
    assign quiet      = rst | rst_q;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) state <= ST_F0;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_F0:   next_state = ST_F1;
            ST_F1:   if (bus.mem_ready) next_state = ST_F2;
            ST_F2:   next_state = ST_DEC;
            ST_DEC: begin
                case (opcode)
                    4'h1:               next_state = ST_MOV;
                    4'h2:               next_state = ST_LDI;
                    4'h3, 4'h4, 4'h5:   next_state = ST_A1;
                    4'h6:               next_state = ST_L0;
                    4'h7:               next_state = ST_S0;
                    4'h8:               next_state = ST_JMP;
                    4'hF:               next_state = ST_HALT;
                    default:            next_state = ST_F0;
                endcase
            end
            ST_MOV, ST_LDI, ST_A3, ST_L2, ST_JMP: next_state = ST_F0;
            ST_A1:   next_state = ST_A2;
            ST_A2:   next_state = ST_A3;
            ST_L0:   next_state = ST_L1;
            ST_L1:   if (bus.mem_ready) next_state = ST_L2;
            ST_S0:   next_state = ST_S1;
            ST_S1:   next_state = ST_S2;
            ST_S2:   if (bus.mem_ready) next_state = ST_F0;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_F0;
        endcase
        if (rst_q) next_state = ST_F0;
    end

    always_comb begin
        bus.reg_ld = 4'b0000;
        bus.reg_t  = 4'b0000;
        bus.pc_ld  = 1'b0;
        bus.pc_t   = 1'b0;
        bus.pc_inc = 1'b0;
        bus.ir_ld  = 1'b0;
        bus.ir_t   = 1'b0;
        bus.mar_ld = 1'b0;
        bus.mdr_ld = 1'b0;
        bus.mdr_t  = 1'b0;
        bus.alu_t  = 1'b0;
        bus.alu_op = 2'b00;
        bus.tmp_ld = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        bus.halted = 1'b0;
        if (!quiet) begin
            case (state)
                ST_F0:  begin bus.pc_t = 1'b1; bus.mar_ld = 1'b1; end
                ST_F1:  begin bus.mem_rd = 1'b1; bus.mdr_ld = 1'b1; end
                ST_F2:  begin bus.mdr_t = 1'b1; bus.ir_ld = 1'b1; bus.pc_inc = 1'b1; end
                ST_MOV: begin bus.reg_t = rs_hot; bus.reg_ld = rd_hot; end
                ST_LDI: begin bus.ir_t = 1'b1; bus.reg_ld = rd_hot; end
                ST_A1:  begin bus.reg_t = rd_hot; bus.tmp_ld = 1'b1; end
                ST_A2:  begin bus.reg_t = rs_hot; bus.alu_op = opcode[1:0] + 2'd2; end
                ST_A3:  begin bus.alu_t = 1'b1; bus.alu_op = opcode[1:0] + 2'd2; bus.reg_ld = rd_hot; end
                ST_L0:  begin bus.ir_t = 1'b1; bus.mar_ld = 1'b1; end
                ST_L1:  begin bus.mem_rd = 1'b1; bus.mdr_ld = 1'b1; end
                ST_L2:  begin bus.mdr_t = 1'b1; bus.reg_ld = rd_hot; end
                ST_S0:  begin bus.ir_t = 1'b1; bus.mar_ld = 1'b1; end
                ST_S1:  begin bus.reg_t = rs_hot; bus.mdr_ld = 1'b1; end
                ST_S2:  bus.mem_wr = 1'b1;
                ST_JMP: begin bus.ir_t = 1'b1; bus.pc_ld = 1'b1; end
                ST_HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if bif();
    multicycle_control_unit dut (.clk(clk), .rst(rst), .bus(bif));

    typedef struct packed {
        logic [3:0] reg_ld;
        logic [3:0] reg_t;
        logic pc_ld, pc_t, pc_inc, ir_ld, ir_t, mar_ld, mdr_ld, mdr_t, alu_t;
        logic [1:0] alu_op;
        logic tmp_ld, mem_rd, mem_wr, halted;
    } ov_t;

    typedef struct {
        ov_t exp;
        int  mr;      // 0/1 driven, 2 = random (ignored by DUT)
        bit  fetch;   // ir_in is don't-care in this cycle
        string tag;
    } step_t;

    step_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic ov_t sample();
        ov_t o;
        o.reg_ld = bif.reg_ld;  o.reg_t = bif.reg_t;
        o.pc_ld = bif.pc_ld;    o.pc_t = bif.pc_t;     o.pc_inc = bif.pc_inc;
        o.ir_ld = bif.ir_ld;    o.ir_t = bif.ir_t;     o.mar_ld = bif.mar_ld;
        o.mdr_ld = bif.mdr_ld;  o.mdr_t = bif.mdr_t;   o.alu_t = bif.alu_t;
        o.alu_op = bif.alu_op;  o.tmp_ld = bif.tmp_ld; o.mem_rd = bif.mem_rd;
        o.mem_wr = bif.mem_wr;  o.halted = bif.halted;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus();
        int drivers;
        drivers = $countones(bif.reg_t) + bif.pc_t + bif.ir_t + bif.mdr_t + bif.alu_t;
        chk("bus_exclusive", (drivers <= 1), 1);
    endtask

    function automatic void push(input ov_t o, input int mr, input bit fetch, input string tag);
        step_t s;
        s.exp = o; s.mr = mr; s.fetch = fetch; s.tag = tag;
        q.push_back(s);
    endfunction

    // Expected per-cycle strobes for one instruction, from the instruction's meaning.
    function automatic void model(input logic [15:0] ins, input int waits, input int halt_cycles);
        ov_t o;
        logic [3:0] op  = ins[15:12];
        logic [3:0] drd = 4'b0001 << ins[11:10];
        logic [3:0] srs = 4'b0001 << ins[9:8];
        o = '0; o.pc_t = 1; o.mar_ld = 1;                 push(o, 2, 1, "F0");
        for (int i = 0; i <= waits; i++) begin
            o = '0; o.mem_rd = 1; o.mdr_ld = 1;           push(o, (i == waits), 1, "F1");
        end
        o = '0; o.mdr_t = 1; o.ir_ld = 1; o.pc_inc = 1;   push(o, 2, 1, "F2");
        o = '0;                                           push(o, 2, 0, "DEC");
        case (op)
            4'h1: begin o = '0; o.reg_t = srs; o.reg_ld = drd; push(o, 2, 0, "MOV"); end
            4'h2: begin o = '0; o.ir_t = 1; o.reg_ld = drd;    push(o, 2, 0, "LDI"); end
            4'h3, 4'h4, 4'h5: begin
                o = '0; o.reg_t = drd; o.tmp_ld = 1;                  push(o, 2, 0, "A1");
                o = '0; o.reg_t = srs; o.alu_op = 2'(op - 4'd2);      push(o, 2, 0, "A2");
                o = '0; o.alu_t = 1; o.alu_op = 2'(op - 4'd2); o.reg_ld = drd;
                push(o, 2, 0, "A3");
            end
            4'h6: begin
                o = '0; o.ir_t = 1; o.mar_ld = 1;                     push(o, 2, 0, "L0");
                for (int i = 0; i <= waits; i++) begin
                    o = '0; o.mem_rd = 1; o.mdr_ld = 1;               push(o, (i == waits), 0, "L1");
                end
                o = '0; o.mdr_t = 1; o.reg_ld = drd;                  push(o, 2, 0, "L2");
            end
            4'h7: begin
                o = '0; o.ir_t = 1; o.mar_ld = 1;                     push(o, 2, 0, "S0");
                o = '0; o.reg_t = srs; o.mdr_ld = 1;                  push(o, 2, 0, "S1");
                for (int i = 0; i <= waits; i++) begin
                    o = '0; o.mem_wr = 1;                             push(o, (i == waits), 0, "S2");
                end
            end
            4'h8: begin o = '0; o.ir_t = 1; o.pc_ld = 1; push(o, 2, 0, "JMP"); end
            4'hF: for (int i = 0; i < halt_cycles; i++) begin
                o = '0; o.halted = 1; push(o, 2, 0, "HALT");
            end
            default: ;
        endcase
    endfunction

    task automatic run_q(input logic [15:0] ins);
        while (q.size() > 0) begin
            step_t s = q.pop_front();
            bif.ir_in     = s.fetch ? 16'($urandom) : ins;
            bif.mem_ready = (s.mr == 2) ? 1'($urandom) : s.mr[0];
            #1;
            chk(s.tag, 32'(sample()), 32'(s.exp));
            chk_bus();
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input logic [15:0] ins, input int waits);
        model(ins, waits, 5);
        run_q(ins);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.ir_in = 16'($urandom); bif.mem_ready = 1'($urandom);
        #1; chk("reset_hold", 32'(sample()), 0);
        @(posedge clk); #1; chk("reset_hold", 32'(sample()), 0);
        @(posedge clk); #1; chk("reset_hold", 32'(sample()), 0);
        rst = 1'b0;
        #1; chk("reset_after", 32'(sample()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        bif.ir_in = '0;
        bif.mem_ready = 1'b1;
        do_reset();

        run_instr(16'h0000, 0);                       // NOP, ready always
        run_instr(16'h2A55, 0);                       // LDI R2,0x55
        run_instr(16'h1600, 0);                       // MOV R1,R2
        run_instr(16'h1500, 1);                       // MOV R1,R1
        run_instr(16'h3400, 0);                       // ADD R1,R0
        run_instr(16'h4E00, 0);                       // SUB R3,R2
        run_instr(16'h5100, 2);                       // AND R0,R1
        run_instr(16'h6C20, 3);                       // LD R3,[0x20], 3 wait cycles
        run_instr(16'h7120, 3);                       // ST
        run_instr(16'h8010, 0);                       // JMP
        run_instr(16'hB0FF, 1);                       // undefined opcode acts as NOP
        run_instr(16'hF000, 0);                       // HLT then stay halted
        do_reset();

        // Reset during an F1 memory wait aborts back to F0.
        model(16'h0000, 4, 0);
        q = q[0:2];
        run_q(16'h0000);
        chk("f1_wait_rd", bif.mem_rd, 1);
        do_reset();
        run_instr(16'h2355, 0);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] ins = 16'($urandom);
            run_instr(ins, $urandom_range(0, 3));
            if (ins[15:12] == 4'hF) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
